// File: rtl/wb_flash_arbiter.sv
// Two-master Wishbone arbiter in front of a read-only flash slave.
// m0 is the instruction bus, m1 the data bus. Ties are broken round-robin,
// every transaction is followed by one idle GAP cycle, a per-grant timeout
// turns a silent slave into an error, and write requests are refused with an
// error pulse without ever reaching the slave.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner, waiting for a master request
// GNT0  | m0 owns the slave, timeout counter running
// GNT1  | m1 owns the slave, timeout counter running
// GAP   | one dead cycle, slave request low; refused-write error shown here
module wb_flash_arbiter #(
    parameter logic [7:0] TMO = 8'd64,
    parameter int         AW  = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_stb_i,
    input  logic          m0_cyc_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_stb_i,
    input  logic          m1_cyc_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_stb_o,
    output logic          s_cyc_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,

    output logic [1:0]    grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    // 1 = m1 was the last owner, so m0 wins the next tie
    logic       last_q, last_d;
    // refused-write error, shown during the GAP cycle that follows the refusal
    logic       werr0_q, werr0_d;
    logic       werr1_q, werr1_d;

    logic       req0, req1;
    logic       gnt0, gnt1;
    logic       tmo_hit;
    logic       pick1;
    logic       win_we;

    // master write data is never forwarded to the read-only slave
    logic       unused_wdata;
    assign unused_wdata = ^{m0_dat_i, m1_dat_i};

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign gnt0    = (state_q == GNT0);
    assign gnt1    = (state_q == GNT1);
    assign tmo_hit = (cnt_q == (TMO - 8'd1));

    // Next-state: arbitration in IDLE, completion/abort/timeout in GNTn
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        werr0_d = 1'b0;
        werr1_d = 1'b0;
        pick1   = 1'b0;
        win_we  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (req0 | req1) begin
                    pick1  = req1 & (~req0 | ~last_q);
                    win_we = pick1 ? m1_we_i : m0_we_i;
                    last_d = pick1;
                    if (win_we) begin
                        state_d = GAP;
                        werr0_d = ~pick1;
                        werr1_d = pick1;
                    end else begin
                        state_d = pick1 ? GNT1 : GNT0;
                    end
                end
            end
            GNT0: begin
                if (s_ack_i || !m0_cyc_i || tmo_hit) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GNT1: begin
                if (s_ack_i || !m1_cyc_i || tmo_hit) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State, timeout counter, last owner and refused-write error flops
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
            werr0_q <= 1'b0;
            werr1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            werr0_q <= werr0_d;
            werr1_q <= werr1_d;
        end
    end

    // Slave request follows the owner; everything decodes from the registered
    // state, so reset silences the bus without waiting for a clock edge.
    always_comb begin
        s_adr_o = '0;
        s_sel_o = 4'h0;
        s_stb_o = 1'b0;
        if (gnt0) begin
            s_adr_o = m0_adr_i;
            s_sel_o = m0_sel_i;
            s_stb_o = req0;
        end else if (gnt1) begin
            s_adr_o = m1_adr_i;
            s_sel_o = m1_sel_i;
            s_stb_o = req1;
        end
    end

    assign s_cyc_o = s_stb_o;
    assign s_we_o  = 1'b0;
    assign s_dat_o = 32'h0;

    assign grant_o = {gnt1, gnt0};

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Ack beats a coincident timeout; a master that already dropped cyc gets no error.
    assign m0_ack_o = gnt0 & s_ack_i;
    assign m1_ack_o = gnt1 & s_ack_i;
    assign m0_err_o = werr0_q | (gnt0 & tmo_hit & ~s_ack_i & m0_cyc_i);
    assign m1_err_o = werr1_q | (gnt1 & tmo_hit & ~s_ack_i & m1_cyc_i);

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Self-checking bench for wb_flash_arbiter: directed scenarios plus random
// episodes compared against a transaction-level timeline model.
module tb_wb_flash_arbiter;
    localparam logic [7:0] TMO = 8'd16;
    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m1_adr, m0_wd, m1_wd;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
    logic [31:0] m0_rd, m1_rd;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] s_adr, s_wd;
    logic [3:0]  s_sel;
    logic        s_we, s_stb, s_cyc;
    logic [31:0] sdat;
    logic        s_ack;
    logic [1:0]  grant;

    int tests_run = 0;
    int tests_failed = 0;
    int lat0 = 255;
    int lat1 = 255;
    int wcnt = 0;
    int model_last = 1;

    logic [1:0]  o_gnt [N];
    logic        o_a0 [N], o_a1 [N], o_e0 [N], o_e1 [N], o_stb [N], o_cyc [N];
    logic [31:0] o_d0 [N], o_d1 [N], o_adr [N];
    logic [1:0]  e_gnt [N];
    logic        e_a0 [N], e_a1 [N], e_e0 [N], e_e1 [N];

    always #5 clk = ~clk;

    wb_flash_arbiter #(.TMO(TMO), .AW(32)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wd), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wd), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_wd), .s_sel_o(s_sel), .s_we_o(s_we), .s_stb_o(s_stb),
        .s_cyc_o(s_cyc), .s_dat_i(sdat), .s_ack_i(s_ack), .grant_o(grant)
    );

    // Slave model: acks on the lat-th consecutive strobed cycle of the owner
    always @(posedge clk) wcnt <= (s_cyc && s_stb) ? wcnt + 1 : 0;
    assign s_ack = s_cyc && s_stb && (wcnt == ((grant[1] ? lat1 : lat0) - 1));

    task automatic idle_masters();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_sel = 0; m0_wd = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_sel = 0; m1_wd = 0;
    endtask

    task automatic do_reset();
        idle_masters();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_last = 1;
    endtask

    task automatic sample(input int c);
        o_gnt[c] = grant; o_a0[c] = m0_ack; o_a1[c] = m1_ack;
        o_e0[c] = m0_err; o_e1[c] = m1_err; o_stb[c] = s_stb; o_cyc[c] = s_cyc;
        o_d0[c] = m0_rd; o_d1[c] = m1_rd; o_adr[c] = s_adr;
    endtask

    // Masters hold their request until they see ack or err; call just after a posedge.
    task automatic run_episode(input logic [1:0] req, input logic we0, input logic we1,
                               input logic [31:0] a0, input logic [31:0] a1, input int n);
        m0_cyc = req[0]; m0_stb = req[0]; m0_we = we0; m0_adr = a0; m0_sel = 4'hF; m0_wd = $urandom;
        m1_cyc = req[1]; m1_stb = req[1]; m1_we = we1; m1_adr = a1; m1_sel = 4'hF; m1_wd = $urandom;
        for (int c = 0; c < n && c < N; c++) begin
            @(negedge clk);
            sample(c);
            @(posedge clk);
            #1;
            if (o_a0[c] || o_e0[c]) begin m0_cyc = 0; m0_stb = 0; m0_we = 0; end
            if (o_a1[c] || o_e1[c]) begin m1_cyc = 0; m1_stb = 0; m1_we = 0; end
        end
        idle_masters();
    endtask

    // Timeline model: cycle 0 is the IDLE cycle in which requests appear.
    // A read of latency L holds the grant min(L,TMO) cycles, ends in ack (L<=TMO)
    // or err, then one GAP and one IDLE cycle. A refused write shows its err in
    // the GAP cycle right after IDLE, then one IDLE cycle.
    task automatic model_episode(input logic [1:0] req, input logic we0, input logic we1,
                                 input int l0, input int l1, output int n);
        int t, k_n, d, m, l;
        int ord [2];
        logic w;
        for (int c = 0; c < N; c++) begin
            e_gnt[c] = 2'b00; e_a0[c] = 0; e_a1[c] = 0; e_e0[c] = 0; e_e1[c] = 0;
        end
        if (req == 2'b11) begin
            ord[0] = (model_last == 1) ? 0 : 1;
            ord[1] = 1 - ord[0];
            k_n = 2;
        end else begin
            ord[0] = req[1] ? 1 : 0;
            ord[1] = 0;
            k_n = 1;
        end
        t = 1;
        for (int k = 0; k < k_n; k++) begin
            m = ord[k];
            w = m ? we1 : we0;
            l = m ? l1 : l0;
            if (w) begin
                if (m == 1) e_e1[t] = 1; else e_e0[t] = 1;
                t += 2;
            end else begin
                d = (l <= int'(TMO)) ? l : int'(TMO);
                for (int i = 0; i < d; i++) e_gnt[t+i] = (m == 1) ? 2'b10 : 2'b01;
                if (l <= int'(TMO)) begin
                    if (m == 1) e_a1[t+d-1] = 1; else e_a0[t+d-1] = 1;
                end else begin
                    if (m == 1) e_e1[t+d-1] = 1; else e_e0[t+d-1] = 1;
                end
                t += d + 2;
            end
            model_last = m;
        end
        n = t;
    endtask

    task automatic test_reset();
        logic [41:0] v;
        idle_masters();
        rst = 1;
        #2;
        v = {grant, s_stb, s_cyc, s_we, m0_ack, m1_ack, m0_err, m1_err, 1'b0, s_wd};
        tests_run++;
        if (v !== 42'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%h exp=0", v);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        int na, ne;
        do_reset();
        lat0 = 13; sdat = 32'hDEAD_BEEF;
        run_episode(2'b01, 0, 0, 32'h0000_0010, 32'h0, 16);
        na = 0; ne = 0;
        for (int c = 0; c < 16; c++) begin na += o_a0[c]; ne += o_e0[c]; end
        tests_run++;
        if (o_adr[1] !== 32'h0000_0010) begin tests_failed++; $display("FAIL read_adr got=%h exp=00000010", o_adr[1]); end
        tests_run++;
        if (o_a0[13] !== 1'b1 || na != 1 || ne != 0) begin
            tests_failed++; $display("FAIL read_ack ack13=%b acks=%0d errs=%0d exp 1,1,0", o_a0[13], na, ne);
        end
        tests_run++;
        if (o_d0[13] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL read_data got=%h exp=deadbeef", o_d0[13]); end
        tests_run++;
        if (o_gnt[13] !== 2'b01 || o_gnt[14] !== 2'b00 || o_cyc[14] !== 1'b0 || o_gnt[15] !== 2'b00) begin
            tests_failed++; $display("FAIL read_gap gnt13=%b gnt14=%b cyc14=%b exp 01,00,0", o_gnt[13], o_gnt[14], o_cyc[14]);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        lat0 = 3; lat1 = 3; sdat = 32'h1234_5678;
        for (int r = 0; r < 2; r++) begin
            run_episode(2'b11, 0, 0, 32'h100, 32'h200, 11);
            tests_run++;
            if (o_gnt[1] !== 2'b01 || o_a0[3] !== 1'b1 || o_gnt[4] !== 2'b00 || o_gnt[5] !== 2'b00) begin
                tests_failed++; $display("FAIL rr_first r=%0d gnt1=%b ack3=%b gnt4=%b exp 01,1,00", r, o_gnt[1], o_a0[3], o_gnt[4]);
            end
            tests_run++;
            if (o_gnt[6] !== 2'b10 || o_a1[8] !== 1'b1 || o_gnt[9] !== 2'b00 || o_adr[6] !== 32'h200) begin
                tests_failed++; $display("FAIL rr_second r=%0d gnt6=%b ack8=%b adr6=%h exp 10,1,200", r, o_gnt[6], o_a1[8], o_adr[6]);
            end
        end
    endtask

    task automatic test_write_err();
        int ne, na, ns;
        do_reset();
        run_episode(2'b10, 0, 1, 32'h0, 32'h40, 4);
        ne = 0; na = 0; ns = 0;
        for (int c = 0; c < 4; c++) begin ne += o_e1[c]; na += o_a1[c]; ns += o_stb[c]; end
        tests_run++;
        if (o_e1[1] !== 1'b1 || ne != 1) begin tests_failed++; $display("FAIL write_err err1=%b errs=%0d exp 1,1", o_e1[1], ne); end
        tests_run++;
        if (na != 0 || ns != 0) begin tests_failed++; $display("FAIL write_noslave acks=%0d stbs=%0d exp 0,0", na, ns); end
    endtask

    task automatic test_timeout();
        int na, ne;
        do_reset();
        lat0 = 255;
        run_episode(2'b01, 0, 0, 32'h80, 32'h0, 19);
        na = 0; ne = 0;
        for (int c = 0; c < 19; c++) begin na += o_a0[c]; ne += o_e0[c]; end
        tests_run++;
        if (o_e0[16] !== 1'b1 || ne != 1 || na != 0 || o_gnt[16] !== 2'b01 || o_gnt[17] !== 2'b00) begin
            tests_failed++; $display("FAIL timeout_err err16=%b errs=%0d acks=%0d gnt17=%b exp 1,1,0,00", o_e0[16], ne, na, o_gnt[17]);
        end
        lat0 = 16; sdat = 32'hCAFE_0001;
        run_episode(2'b01, 0, 0, 32'h84, 32'h0, 19);
        na = 0; ne = 0;
        for (int c = 0; c < 19; c++) begin na += o_a0[c]; ne += o_e0[c]; end
        tests_run++;
        if (o_a0[16] !== 1'b1 || na != 1 || ne != 0) begin
            tests_failed++; $display("FAIL timeout_ack_wins ack16=%b acks=%0d errs=%0d exp 1,1,0", o_a0[16], na, ne);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] v;
        bit seen;
        do_reset();
        lat1 = 255;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300; m1_sel = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            sample(c);
            if (c < 5) begin @(posedge clk); #1; end
        end
        tests_run++;
        if (o_gnt[5] !== 2'b10) begin tests_failed++; $display("FAIL rstmid_pre gnt=%b exp 10", o_gnt[5]); end
        #1 rst = 1;
        #1;
        v = {grant, s_cyc, s_stb, m1_ack, m1_err, m0_err};
        tests_run++;
        if (v !== 7'd0) begin tests_failed++; $display("FAIL rstmid_async got=%b exp 0000000", v); end
        idle_masters();
        @(negedge clk);
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h20; m0_sel = 4'hF; lat0 = 2;
        #1 rst = 0;
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b01 || m1_ack !== 1'b0 || m1_err !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_first_grant gnt=%b ack1=%b err1=%b exp 01,0,0", grant, m1_ack, m1_err);
        end
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (m0_ack) seen = 1;
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL rstmid_after ack seen=0 exp 1"); end
        @(posedge clk); #1;
        idle_masters();
        repeat (3) @(posedge clk);
        #1;
        model_last = 0;
    endtask

    task automatic test_abort();
        int na, ne;
        do_reset();
        lat1 = 255;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h500; m1_sel = 4'hF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            sample(c);
            @(posedge clk);
            #1;
            if (c == 3) m1_cyc = 0;
        end
        idle_masters();
        na = 0; ne = 0;
        for (int c = 0; c < 8; c++) begin na += o_a1[c]; ne += o_e1[c]; end
        tests_run++;
        if (o_gnt[3] !== 2'b10 || o_cyc[3] !== 1'b1 || o_cyc[4] !== 1'b0 || o_gnt[5] !== 2'b00 || o_cyc[5] !== 1'b0) begin
            tests_failed++; $display("FAIL abort_gap gnt3=%b cyc3=%b cyc4=%b gnt5=%b exp 10,1,0,00", o_gnt[3], o_cyc[3], o_cyc[4], o_gnt[5]);
        end
        tests_run++;
        if (na != 0 || ne != 0) begin tests_failed++; $display("FAIL abort_noterm acks=%0d errs=%0d exp 0,0", na, ne); end
        model_last = 1;
    endtask

    task automatic test_random();
        logic [1:0]  req;
        logic        w0, w1;
        int          l0, l1, n;
        logic [31:0] a0, a1, ea;
        logic [6:0]  ov, ev;
        do_reset();
        for (int e = 0; e < 40; e++) begin
            req = 2'($urandom_range(1, 3));
            w0 = ($urandom_range(0, 3) == 0);
            w1 = ($urandom_range(0, 3) == 0);
            l0 = $urandom_range(1, 20);
            l1 = $urandom_range(1, 20);
            a0 = $urandom; a1 = $urandom;
            sdat = $urandom;
            lat0 = l0; lat1 = l1;
            model_episode(req, w0, w1, l0, l1, n);
            run_episode(req, w0, w1, a0, a1, n);
            for (int c = 0; c < n; c++) begin
                ev = {e_gnt[c], e_a0[c], e_a1[c], e_e0[c], e_e1[c], (e_gnt[c] != 2'b00)};
                ov = {o_gnt[c], o_a0[c], o_a1[c], o_e0[c], o_e1[c], o_stb[c]};
                tests_run++;
                if (ov !== ev) begin
                    tests_failed++;
                    $display("FAIL random_timeline ep=%0d c=%0d got=%b exp=%b (gnt,a0,a1,e0,e1,stb)", e, c, ov, ev);
                end
                if (e_gnt[c] != 2'b00) begin
                    ea = e_gnt[c][1] ? a1 : a0;
                    tests_run++;
                    if (o_adr[c] !== ea) begin
                        tests_failed++; $display("FAIL random_adr ep=%0d c=%0d got=%h exp=%h", e, c, o_adr[c], ea);
                    end
                end
                if (e_a0[c] || e_a1[c]) begin
                    tests_run++;
                    if ((e_a0[c] ? o_d0[c] : o_d1[c]) !== sdat) begin
                        tests_failed++; $display("FAIL random_data ep=%0d c=%0d got=%h exp=%h", e, c, e_a0[c] ? o_d0[c] : o_d1[c], sdat);
                    end
                end
            end
        end
    endtask

    initial begin
        sdat = 32'h0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_err();
        test_timeout();
        test_reset_mid();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
